// File: rtl/pipe_reg_chain.sv
// Parameterized in-order pipeline register chain with load-use hazard stall,
// external freeze, young-stage flush and saturating stall/flush event counters.
module pipe_reg_chain #(
  parameter int IR_W         = 32,
  parameter int PC_W         = 8,
  parameter int CTRL_W       = 12,
  parameter int STAGES       = 4,
  parameter int MEMRD_BIT    = 0,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [IR_W-1:0]            in_ir,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       stall_req,
  input  logic                       flush_req,
  output logic                       in_ready,
  output logic                       hazard_stall,
  output logic [STAGES-1:0]          st_valid,
  output logic [STAGES*IR_W-1:0]     st_ir,
  output logic [STAGES*PC_W-1:0]     st_pc,
  output logic [STAGES*CTRL_W-1:0]   st_ctrl,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic [IR_W-1:0]   ir;
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t [STAGES-1:0] st, nxt;
  stage_t              feed;
  logic                hold;
  logic [4:0]          rt1;

  // Load in stage 1 whose destination (rt) is a source of the instruction in stage 0.
  assign rt1          = st[1].ir[20:16];
  assign hazard_stall = st[1].valid & st[1].ctrl[MEMRD_BIT] & (rt1 != 5'd0) & st[0].valid &
                        ((rt1 == st[0].ir[25:21]) | (rt1 == st[0].ir[20:16]));
  assign hold         = stall_req | hazard_stall;
  assign in_ready     = ~hold & ~reset;

  always_comb begin
    feed = BUBBLE;
    if (in_valid) feed = '{valid: 1'b1, ir: in_ir, pc: in_pc, ctrl: in_ctrl};
  end

  // Flush wins over any hold for the young stages; stage 0 only moves when not held.
  always_comb begin
    nxt = st;
    if (flush_req)  nxt[0] = BUBBLE;
    else if (!hold) nxt[0] = feed;
    for (int k = 1; k < STAGES; k++) begin
      if (flush_req && k < FLUSH_STAGES)  nxt[k] = BUBBLE;
      else if (stall_req)                 nxt[k] = st[k];
      else if (hazard_stall && k == 1)    nxt[k] = BUBBLE;
      else                                nxt[k] = st[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      st <= nxt;
      if (hold && stall_cnt != 16'hFFFF)      stall_cnt <= stall_cnt + 16'd1;
      if (flush_req && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_out
    assign st_valid[k]                  = st[k].valid;
    assign st_ir[k*IR_W +: IR_W]        = st[k].ir;
    assign st_pc[k*PC_W +: PC_W]        = st[k].pc;
    assign st_ctrl[k*CTRL_W +: CTRL_W]  = st[k].ctrl;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 Parameter IR_W, default 32, instruction width per stage.
REQ-002 Parameter PC_W, default 8, instruction-address width per stage.
REQ-003 Parameter CTRL_W, default 12, control-bundle width per stage.
REQ-004 Parameter STAGES, default 4, number of pipeline registers (legal 2..8); stage 0 = IF/ID, stage k fed from stage k-1.
REQ-005 Parameter MEMRD_BIT, default 0, index of mem_read inside a ctrl bundle.
REQ-006 Parameter FLUSH_STAGES, default 2, count of youngest stages cleared by a flush (legal 1..STAGES).
REQ-007 clock  input  1  sole clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  fetch slot holds a real instruction.
REQ-010 in_ir  input  IR_W  fetched instruction.
REQ-011 in_pc  input  PC_W  address of fetched instruction.
REQ-012 in_ctrl  input  CTRL_W  control bundle for the fetched instruction.
REQ-013 stall_req  input  1  external freeze request (memory wait).
REQ-014 flush_req  input  1  taken branch/jump; kill younger stages.
REQ-015 in_ready  output  1  stage 0 accepts input this cycle.
REQ-016 hazard_stall  output  1  load-use hazard detected this cycle.
REQ-017 st_valid  output  STAGES  valid bit per stage, bit k = stage k.
REQ-018 st_ir  output  STAGES*IR_W  flattened IR per stage, stage k at [k*IR_W +: IR_W].
REQ-019 st_pc  output  STAGES*PC_W  flattened PC per stage, same packing.
REQ-020 st_ctrl  output  STAGES*CTRL_W  flattened ctrl per stage, same packing.
REQ-021 stall_cnt  output  16  cycles with hold asserted, saturating.
REQ-022 flush_cnt  output  16  flush events accepted, saturating.

Function
REQ-023 hazard_stall SHALL be combinational: st_valid[1] & ctrl1[MEMRD_BIT] & (ir1[20:16] != 0) & st_valid[0] & (ir1[20:16] == ir0[25:21] | ir1[20:16] == ir0[20:16]).
REQ-024 hold = stall_req | hazard_stall; in_ready SHALL equal ~hold & ~reset.
REQ-025 Bubble SHALL mean valid=0, ir=0, pc=0, ctrl=0.
REQ-026 No hold, no flush: stage 0 loads {in_ir,in_pc,in_ctrl} with valid=in_valid (bubble if in_valid=0); every stage k>0 loads stage k-1; latency input->stage k = k+1 cycles.
REQ-027 stall_req=1: all stages SHALL retain contents, except as REQ-029 overrides.
REQ-028 hazard_stall=1, stall_req=0: stage 0 retains, stage 1 loads bubble, stages >=2 advance normally.
REQ-029 flush_req=1: stages 0..FLUSH_STAGES-1 SHALL load bubbles next cycle regardless of stall_req/hazard_stall; older stages follow REQ-026..028.
REQ-030 Priority: reset > flush (young stages) > stall_req > hazard_stall > normal advance.
REQ-031 Input presented while in_ready=0 SHALL be ignored; source re-presents it.
REQ-032 stall_cnt SHALL increment by 1 each cycle hold=1, holding at 16'hFFFF.
REQ-033 flush_cnt SHALL increment by 1 each cycle flush_req=1, holding at 16'hFFFF.
REQ-034 Only registered state SHALL drive st_* outputs; no combinational input-to-st_* path.

Reset
REQ-035 reset=1 at a clock edge SHALL clear all stages to bubbles and both counters to 0, overriding every other input.
REQ-036 During reset in_ready SHALL be 0; hazard_stall SHALL be 0 on the first cycle after reset.
REQ-037 Reset asserted mid-stall or mid-flush SHALL leave no residual hold; first post-reset cycle advances normally.

Verification
REQ-038 Stream: pc 0,4,8,12 with in_valid=1, no stalls -> stage 3 shows pc 0 at cycle 4 after first input, then 4,8,12 on consecutive cycles.
REQ-039 Load-use: stage1 = lw rt=5 (mem_read=1), stage0 = add rs=5 -> hazard_stall=1, in_ready=0, next cycle st_valid[1]=0, stage 0 unchanged, stall_cnt=1.
REQ-040 Hazard on $0: stage1 lw rt=0, stage0 rs=0 -> hazard_stall=0, chain advances.
REQ-041 flush_req one cycle with stages 0..3 valid -> next cycle st_valid=4'b1100 (stages 0,1 bubbled; older advanced), flush_cnt=1.
REQ-042 flush_req and stall_req together -> stages 0,1 bubbled, stages 2,3 retained; stall_cnt and flush_cnt each +1.
REQ-043 Hold stall_req 70000 cycles -> stall_cnt=16'hFFFF and stays; reset -> 0 next cycle, st_valid=0.
